// File: rtl/rect_anim_pkg.sv
// Shared types and screen constants for the rectangle animator.
package rect_anim_pkg;
  typedef enum logic [2:0] {IDLE, ARM, DRAW, WAIT, ERASE, MOVE} state_t;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;
endpackage

// File: rtl/frame_timer.sv
// Frame-interval timer: FRAME_DELAY clocks per frame, one step_tick pulse
// on the last clock of the FRAMES_PER_STEP-th frame while enabled.
module frame_timer #(
  parameter int FRAME_DELAY     = 833_334,
  parameter int FRAMES_PER_STEP = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic step_tick
);
  localparam int CW = (FRAME_DELAY > 1) ? $clog2(FRAME_DELAY) : 1;
  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_DELAY - 1);
  localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_STEP - 1);

  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_frame;
  logic          w_frame_tick;

  assign w_frame_tick = en && (r_cnt == C_LAST);
  assign step_tick    = w_frame_tick && (r_frame == F_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_frame <= '0;
    end else if (clr) begin
      r_cnt   <= '0;
      r_frame <= '0;
    end else if (en) begin
      if (w_frame_tick) begin
        r_cnt   <= '0;
        r_frame <= (r_frame == F_LAST) ? '0 : r_frame + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/rect_animator.sv
// Draw / hold / erase / move-up animator for NUM_OBJ solid rectangles, one pixel per clock.
// Optional RECT_ANIM_CLIP_EN suppresses plots that fall off the 160x120 screen.
module rect_animator
  import rect_anim_pkg::*;
#(
  parameter int         NUM_OBJ         = 2,
  parameter int         RECT_W          = 40,
  parameter int         RECT_H          = 5,
  parameter int         FRAME_DELAY     = 833_334,
  parameter int         FRAMES_PER_STEP = 15,
  parameter int         Y_WRAP          = 116,
  parameter logic [2:0] DRAW_COLOUR     = 3'b100
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 stop,
  input  logic [NUM_OBJ*8-1:0] obj_x_init,
  input  logic [NUM_OBJ*7-1:0] obj_y_init,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 step_done
);
  localparam int PX_W  = (RECT_W > 1) ? $clog2(RECT_W) : 1;
  localparam int PY_W  = (RECT_H > 1) ? $clog2(RECT_H) : 1;
  localparam int OBJ_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(RECT_W - 1);
  localparam logic [PY_W-1:0]  PY_LAST  = PY_W'(RECT_H - 1);
  localparam logic [OBJ_W-1:0] OBJ_LAST = OBJ_W'(NUM_OBJ - 1);
  localparam logic [6:0]       Y_LOAD   = 7'(Y_WRAP);

  state_t r_state, w_next;
  logic [PX_W-1:0]  r_px;
  logic [PY_W-1:0]  r_py;
  logic [OBJ_W-1:0] r_obj;
  logic [NUM_OBJ-1:0][7:0] r_pos_x;
  logic [NUM_OBJ-1:0][6:0] r_pos_y;
  logic w_scan, w_last, w_step_tick, w_on_screen;
  logic [7:0] w_pos_x, w_pix_x;
  logic [6:0] w_pos_y, w_pix_y;

  assign w_scan  = (r_state == DRAW) || (r_state == ERASE);
  assign w_last  = (r_obj == OBJ_LAST) && (r_py == PY_LAST) && (r_px == PX_LAST);
  assign w_pos_x = r_pos_x[r_obj];
  assign w_pos_y = r_pos_y[r_obj];

`ifdef RECT_ANIM_CLIP_EN
  logic [8:0] w_x_full;
  logic [7:0] w_y_full;
  assign w_x_full    = {1'b0, w_pos_x} + 9'(r_px);
  assign w_y_full    = {1'b0, w_pos_y} + 8'(r_py);
  assign w_pix_x     = w_x_full[7:0];
  assign w_pix_y     = w_y_full[6:0];
  assign w_on_screen = (w_x_full < 9'(SCREEN_W)) && (w_y_full < 8'(SCREEN_H));
`else
  assign w_pix_x     = w_pos_x + 8'(r_px);
  assign w_pix_y     = w_pos_y + 7'(r_py);
  assign w_on_screen = 1'b1;
`endif

  frame_timer #(.FRAME_DELAY(FRAME_DELAY), .FRAMES_PER_STEP(FRAMES_PER_STEP)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clr      (r_state != WAIT),
    .en       (r_state == WAIT),
    .step_tick(w_step_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    step_done = 1'b0;
    unique case (r_state)
      IDLE:    begin busy = 1'b0; if (go) w_next = ARM; end
      ARM:     begin busy = 1'b0; if (!go) w_next = DRAW; end
      DRAW:    if (w_last) w_next = WAIT;
      WAIT:    if (w_step_tick) w_next = ERASE;
      ERASE:   if (w_last) w_next = stop ? IDLE : MOVE;
      MOVE:    begin step_done = 1'b1; w_next = DRAW; end
      default: w_next = IDLE;
    endcase
  end

  // px fastest, then py, then obj; a full pass leaves all three at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_px  <= '0;
      r_py  <= '0;
      r_obj <= '0;
    end else if (w_scan) begin
      if (r_px == PX_LAST) begin
        r_px <= '0;
        if (r_py == PY_LAST) begin
          r_py  <= '0;
          r_obj <= (r_obj == OBJ_LAST) ? '0 : r_obj + 1'b1;
        end else begin
          r_py <= r_py + 1'b1;
        end
      end else begin
        r_px <= r_px + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pos_x <= obj_x_init;
      r_pos_y <= obj_y_init;
    end else if (r_state == IDLE) begin
      r_pos_x <= obj_x_init;
      r_pos_y <= obj_y_init;
    end else if (r_state == MOVE) begin
      for (int i = 0; i < NUM_OBJ; i++)
        r_pos_y[i] <= (r_pos_y[i] == 7'd0) ? Y_LOAD : r_pos_y[i] - 7'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      plot       <= 1'b0;
    end else begin
      plot <= 1'b0;
      if (w_scan) begin
        vga_x      <= w_pix_x;
        vga_y      <= w_pix_y;
        vga_colour <= (r_state == DRAW) ? DRAW_COLOUR : COLOUR_BLACK;
        plot       <= w_on_screen;
      end
    end
  end
endmodule

// File: tb/tb_rect_animator.sv
// Randomized scoreboard bench for rect_animator: a pixel-list reference model fills
// an expected queue, a negedge monitor pops and compares every plotted pixel.
module tb_rect_animator;
  localparam int NO = 2, RW = 4, RH = 2, FD = 3, FPS = 2, YW = 116;
  localparam int PASS_PIX = NO * RW * RH;
  localparam int DC = 4;

  logic clock = 1'b0, reset = 1'b1, go = 1'b0, stop = 1'b0;
  logic [NO*8-1:0] obj_x_init = '0;
  logic [NO*7-1:0] obj_y_init = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic plot, busy, step_done;

  rect_animator #(
    .NUM_OBJ(NO), .RECT_W(RW), .RECT_H(RH), .FRAME_DELAY(FD),
    .FRAMES_PER_STEP(FPS), .Y_WRAP(YW), .DRAW_COLOUR(3'b100)
  ) dut (
    .clock(clock), .reset(reset), .go(go), .stop(stop),
    .obj_x_init(obj_x_init), .obj_y_init(obj_y_init),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .plot(plot), .busy(busy), .step_done(step_done)
  );

  always #5 clock = ~clock;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];
  int   plot_cyc[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, sd_cnt = 0;
  int   mx[NO], my[NO];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every plotted pixel must match the head of the expected queue
  always @(negedge clock) begin : mon
    pix_t e;
    cyc++;
    if (step_done) sd_cnt++;
    if (plot) begin
      plot_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_plot", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("pix_x", int'(vga_x), e.x);
        chk("pix_y", int'(vga_y), e.y);
        chk("pix_colour", int'(vga_colour), e.c);
      end
    end
  end

  task automatic set_init(input int x0, input int y0, input int x1, input int y1);
    obj_x_init = {8'(x1), 8'(x0)};
    obj_y_init = {7'(y1), 7'(y0)};
    mx[0] = x0; my[0] = y0; mx[1] = x1; my[1] = y1;
  endtask

  task automatic push_scan(input int c);
    pix_t p;
    for (int o = 0; o < NO; o++)
      for (int py = 0; py < RH; py++)
        for (int px = 0; px < RW; px++) begin
`ifdef RECT_ANIM_CLIP_EN
          if (mx[o] + px >= 160 || my[o] + py >= 120) continue;
`endif
          p.x = (mx[o] + px) % 256;
          p.y = (my[o] + py) % 128;
          p.c = c;
          exp_q.push_back(p);
        end
  endtask

  task automatic model_move();
    for (int o = 0; o < NO; o++) my[o] = (my[o] == 0) ? YW : my[o] - 1;
  endtask

  task automatic pulse_go();
    @(posedge clock); #1 go = 1'b1;
    repeat (2) @(posedge clock);
    #1 go = 1'b0;
  endtask

  // n draw/erase passes with n-1 moves; stop is raised so the n-th erase ends in IDLE
  task automatic run_steps(input int n);
    int sd0, pc0, got;
    bit ok;
    sd0 = sd_cnt;
    pc0 = plot_cyc.size();
    for (int s = 0; s < n; s++) begin
      push_scan(DC);
      push_scan(0);
      if (s < n - 1) model_move();
    end
    pulse_go();
    if (n == 1) stop = 1'b1;
    ok = 1'b0;
    repeat (20) begin
      @(posedge clock); #1;
      if (busy) begin ok = 1'b1; break; end
    end
    chk("busy_rise_timeout", int'(ok), 1);
    go = 1'b1; @(posedge clock); #1 go = 1'b0;
    if (n > 1) begin
      ok = 1'b0;
      repeat (n * 45 + 20) begin
        @(posedge clock); #1;
        if (sd_cnt - sd0 >= n - 1) begin ok = 1'b1; break; end
      end
      chk("step_wait_timeout", int'(ok), 1);
      stop = 1'b1;
    end
    ok = 1'b0;
    repeat (n * 45 + 20) begin
      @(posedge clock); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("busy_fall_timeout", int'(ok), 1);
    stop = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("queue_left", exp_q.size(), 0);
    chk("step_done_count", sd_cnt - sd0, n - 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_plot", int'(plot), 0);
`ifndef RECT_ANIM_CLIP_EN
    got = plot_cyc.size() - pc0;
    chk("plot_count", got, 2 * n * PASS_PIX);
    if (got == 2 * n * PASS_PIX)
      for (int p = 0; p < 2 * n; p++) begin
        int b;
        b = pc0 + p * PASS_PIX;
        chk("pass_contiguous", plot_cyc[b + PASS_PIX - 1] - plot_cyc[b], PASS_PIX - 1);
        if (p % 2 == 1) chk("draw_to_erase_gap", plot_cyc[b] - plot_cyc[b - 1], FD * FPS + 1);
        else if (p > 0) chk("erase_to_draw_gap", plot_cyc[b] - plot_cyc[b - 1], 2);
      end
`endif
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int pc0;
    set_init(10, 20, 50, 0);
    #1;
    chk("rst_plot", int'(plot), 0);
    chk("rst_x", int'(vga_x), 0);
    chk("rst_y", int'(vga_y), 0);
    chk("rst_colour", int'(vga_colour), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step_done", int'(step_done), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // directed: first draw (10,20)..(53,1), move to y=19 / wrap to 116
    run_steps(2);

    // reset mid-DRAW, then restart: positions must come from init again
    set_init(158, 126, 254, 0);
    pc0 = plot_cyc.size();
    push_scan(DC);
    pulse_go();
    ok = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (plot_cyc.size() - pc0 >= 5) begin ok = 1'b1; break; end
    end
    chk("mid_draw_timeout", int'(ok), 1);
    @(posedge clock); #1;
    chk("pre_reset_busy", int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_plot", int'(plot), 0);
    chk("midrst_x", int'(vga_x), 0);
    chk("midrst_y", int'(vga_y), 0);
    chk("midrst_colour", int'(vga_colour), 0);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clock); #1 reset = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1 chk("post_reset_plot", int'(plot), 0);
    run_steps(2);

    // randomized positions and step counts
    for (int r = 0; r < 4; r++) begin
      set_init($urandom_range(0, 255), $urandom_range(0, 127),
               $urandom_range(0, 255), $urandom_range(0, 2));
      run_steps($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
